// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: FSM states and counter widths.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_e;

  localparam int unsigned SECS_PER_MIN = 60;
  localparam int unsigned RING_CNT_W   = 8;
  localparam int unsigned SNZ_CNT_W    = 12;

endpackage

// File: rtl/alarm_controller_match.sv
// Time/alarm comparator with a registered copy of the match so only its rising edge triggers.
module alarm_controller_match
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cur_hours_i,
  input  logic [5:0] cur_mins_i,
  input  logic       cur_am_pm_i,
  input  logic [3:0] alm_hours_i,
  input  logic [5:0] alm_mins_i,
  input  logic       alm_am_pm_i,
  input  logic       alarm_en_i,
  output logic       trigger_o
);

  logic match;
  logic match_q;

  assign match = alarm_en_i
               && (cur_hours_i == alm_hours_i)
               && (cur_mins_i  == alm_mins_i)
               && (cur_am_pm_i == alm_am_pm_i);

  // Resets high so a match already present when reset is released does not ring.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b1;
    end else begin
      match_q <= match;
    end
  end

  assign trigger_o = match && !match_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm ring/snooze/stop state machine with ring timeout, snooze countdown and 1 s buzzer cadence.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MINS       = 5,
  parameter int unsigned RING_TIMEOUT_SECS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_tick,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_mins,
  input  logic       cur_am_pm,
  input  logic [3:0] alm_hours,
  input  logic [5:0] alm_mins,
  input  logic       alm_am_pm,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic       buzz,
  output logic       snoozing
);

  localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_TIMEOUT_SECS - 1);
  localparam logic [SNZ_CNT_W-1:0]  SNZ_LOAD  = SNZ_CNT_W'(SNOOZE_MINS * SECS_PER_MIN);

  alarm_state_e          state_q, state_d;
  logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_CNT_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic                  phase_q, phase_d;
  logic                  trigger;

  alarm_controller_match u_match (
    .clk         (clk),
    .reset_n     (reset_n),
    .cur_hours_i (cur_hours),
    .cur_mins_i  (cur_mins),
    .cur_am_pm_i (cur_am_pm),
    .alm_hours_i (alm_hours),
    .alm_mins_i  (alm_mins),
    .alm_am_pm_i (alm_am_pm),
    .alarm_en_i  (alarm_en),
    .trigger_o   (trigger)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      phase_q    <= phase_d;
    end
  end

  // Key presses outrank the tick, so a coincident tick is simply not counted.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    phase_d    = phase_q;
    if (!alarm_en) begin
      state_d    = IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
      phase_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
          phase_d    = 1'b0;
          if (trigger) begin
            state_d = RINGING;
            phase_d = 1'b1;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            phase_d    = 1'b0;
          end else if (snooze) begin
            state_d    = SNOOZE;
            snz_cnt_d  = SNZ_LOAD;
            ring_cnt_d = '0;
          end else if (sec_tick) begin
            if (ring_cnt_q == RING_LAST) begin
              state_d    = IDLE;
              ring_cnt_d = '0;
              phase_d    = 1'b0;
            end else begin
              ring_cnt_d = ring_cnt_q + 1'b1;
              phase_d    = !phase_q;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
            phase_d   = 1'b0;
          end else if (sec_tick) begin
            if (snz_cnt_q == SNZ_CNT_W'(1)) begin
              state_d    = RINGING;
              snz_cnt_d  = '0;
              ring_cnt_d = '0;
              phase_d    = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
          phase_d    = 1'b0;
        end
      endcase
    end
  end

  assign ring     = (state_q == RINGING);
  assign buzz     = ring && phase_q;
  assign snoozing = (state_q == SNOOZE);

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: expected outputs queued per step, popped and checked after the edge.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sec_tick, snooze, stop, alarm_en;
  logic [3:0] cur_hours, alm_hours;
  logic [5:0] cur_mins, alm_mins;
  logic       cur_am_pm, alm_am_pm;
  logic       ring, buzz, snoozing;

  typedef struct {
    string      tag;
    logic [2:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  alarm_controller #(.SNOOZE_MINS(5), .RING_TIMEOUT_SECS(60)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sec_tick  (sec_tick),
    .cur_hours (cur_hours),
    .cur_mins  (cur_mins),
    .cur_am_pm (cur_am_pm),
    .alm_hours (alm_hours),
    .alm_mins  (alm_mins),
    .alm_am_pm (alm_am_pm),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .stop      (stop),
    .ring      (ring),
    .buzz      (buzz),
    .snoozing  (snoozing)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic r, input logic b, input logic s);
    exp_t e;
    e.tag = tag;
    e.val = {r, b, s};
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [2:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = {ring, buzz, snoozing};
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: ring/buzz/snoozing observed=%b expected=%b", e.tag, obs, e.val);
      end
      $display("t=%0t %s ring/buzz/snoozing=%b expected=%b", $time, e.tag, obs, e.val);
    end
  endtask

  // One clock cycle with the given pulses; leaves time at posedge+1 with pulses cleared.
  task automatic cyc(input logic tk, input logic snz, input logic stp);
    sec_tick = tk;
    snooze   = snz;
    stop     = stp;
    @(posedge clk);
    #1;
    sec_tick = 1'b0;
    snooze   = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic tick_gap();
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_cur(input logic [3:0] h, input logic [5:0] m, input logic ap);
    cur_hours = h; cur_mins = m; cur_am_pm = ap;
  endtask

  task automatic set_alm(input logic [3:0] h, input logic [5:0] m, input logic ap);
    alm_hours = h; alm_mins = m; alm_am_pm = ap;
  endtask

  initial begin
    reset_n = 1'b0;
    sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0; alarm_en = 1'b1;
    set_alm(4'd7, 6'd30, 1'b0);
    set_cur(4'd7, 6'd29, 1'b0);
    #2;
    push_exp("reset_outputs", 1'b0, 1'b0, 1'b0);
    check_out();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    push_exp("idle_7_29", 1'b0, 1'b0, 1'b0);
    check_out();

    // Minute rolls to 7:30 AM: ring and buzz one cycle later.
    set_cur(4'd7, 6'd30, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    push_exp("ring_on_match", 1'b1, 1'b1, 1'b0);
    check_out();
    for (int k = 1; k <= 59; k++) begin
      tick_gap();
      push_exp($sformatf("ring_tick_%0d", k), 1'b1, (k % 2 == 0), 1'b0);
      check_out();
    end
    tick_gap();
    push_exp("timeout_60th_tick", 1'b0, 1'b0, 1'b0);
    check_out();
    repeat (5) tick_gap();
    push_exp("no_rering_same_min", 1'b0, 1'b0, 1'b0);
    check_out();

    // Editing the alarm onto the current time triggers; then snooze.
    set_cur(4'd7, 6'd31, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    set_alm(4'd7, 6'd31, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    push_exp("ring_on_alarm_edit", 1'b1, 1'b1, 1'b0);
    check_out();
    repeat (3) tick_gap();
    push_exp("ring_after_3_ticks", 1'b1, 1'b0, 1'b0);
    check_out();
    cyc(1'b1, 1'b1, 1'b0);
    push_exp("snooze_with_tick", 1'b0, 1'b0, 1'b1);
    check_out();
    cyc(1'b0, 1'b1, 1'b0);
    push_exp("snooze_in_snooze_ignored", 1'b0, 1'b0, 1'b1);
    check_out();
    for (int k = 1; k <= 299; k++) begin
      tick_gap();
      if (k % 100 == 0 || k == 299) begin
        push_exp($sformatf("snoozing_tick_%0d", k), 1'b0, 1'b0, 1'b1);
        check_out();
      end
    end
    tick_gap();
    push_exp("snooze_expiry_300", 1'b1, 1'b1, 1'b0);
    check_out();
    tick_gap();
    push_exp("rering_toggle", 1'b1, 1'b0, 1'b0);
    check_out();

    // Stop coincident with a tick wins.
    cyc(1'b1, 1'b0, 1'b1);
    push_exp("stop_with_tick", 1'b0, 1'b0, 1'b0);
    check_out();
    repeat (3) tick_gap();
    push_exp("idle_after_stop", 1'b0, 1'b0, 1'b0);
    check_out();

    // Stop during snooze: no later ring.
    set_cur(4'd7, 6'd32, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    set_alm(4'd7, 6'd32, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    push_exp("ring_7_32", 1'b1, 1'b1, 1'b0);
    check_out();
    cyc(1'b0, 1'b1, 1'b0);
    push_exp("snooze_7_32", 1'b0, 1'b0, 1'b1);
    check_out();
    repeat (10) tick_gap();
    cyc(1'b0, 1'b0, 1'b1);
    push_exp("stop_in_snooze", 1'b0, 1'b0, 1'b0);
    check_out();
    repeat (310) tick_gap();
    push_exp("no_ring_after_snooze_stop", 1'b0, 1'b0, 1'b0);
    check_out();

    // AM/PM mismatch and disabled alarm must not ring.
    set_alm(4'd8, 6'd0, 1'b0);
    set_cur(4'd8, 6'd0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    push_exp("ampm_mismatch", 1'b0, 1'b0, 1'b0);
    check_out();
    alarm_en = 1'b0;
    set_alm(4'd8, 6'd0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    push_exp("disabled_match", 1'b0, 1'b0, 1'b0);
    check_out();
    alarm_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    push_exp("enable_edge_rings", 1'b1, 1'b1, 1'b0);
    check_out();
    alarm_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    push_exp("disable_in_ring", 1'b0, 1'b0, 1'b0);
    check_out();
    alarm_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    push_exp("reenable_rerings", 1'b1, 1'b1, 1'b0);
    check_out();

    // Asynchronous reset mid-snooze while the time still matches.
    cyc(1'b0, 1'b1, 1'b0);
    push_exp("snooze_before_reset", 1'b0, 1'b0, 1'b1);
    check_out();
    #2;
    reset_n = 1'b0;
    #1;
    push_exp("async_reset_immediate", 1'b0, 1'b0, 1'b0);
    check_out();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) tick_gap();
    push_exp("no_ring_after_release", 1'b0, 1'b0, 1'b0);
    check_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
